// File: rtl/execute_unit.sv
// Execute unit: single-cycle ALU plus an iterative shift-add multiplier and
// restoring divider, wrapped in a valid/ready request and result interface.
module execute_unit #(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [3:0]      alu_op_i,
  input  logic            alub_sel_i,
  input  logic [XLEN-1:0] alu_A_i,
  input  logic [XLEN-1:0] rf_rd2_i,
  input  logic [XLEN-1:0] sext_ext_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] alu_C_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a request transfers on a rising edge where in_valid_i and
  // in_ready_o are both high; a result transfers where out_valid_o and
  // out_ready_i are both high. Neither valid may depend on its ready.

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_MAX = SHW'(XLEN - 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_REMU  = 4'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic            alive_q;
  logic            valid_q;
  logic [XLEN-1:0] alu_c_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] op_q;
  logic            is_div_q;
  logic            sel_hi_q;

  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic            is_muldiv;
  logic            accept;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] hi_d;
  logic [XLEN-1:0] lo_d;
  logic [XLEN-1:0] md_res;

  assign op_b       = alub_sel_i ? sext_ext_i : rf_rd2_i;
  assign shamt      = op_b[SHW-1:0];
  assign is_muldiv  = MULDIV_EN && (alu_op_i >= OP_MUL) && (alu_op_i <= OP_REMU);
  // alive_q keeps the unit closed until the first edge after reset release.
  assign in_ready_o = alive_q && !flush_i &&
                      ((state_q == IDLE) || ((state_q == DONE) && out_ready_i));
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      OP_ADD:  alu_res = alu_A_i + op_b;
      OP_SUB:  alu_res = alu_A_i - op_b;
      OP_AND:  alu_res = alu_A_i & op_b;
      OP_OR:   alu_res = alu_A_i | op_b;
      OP_XOR:  alu_res = alu_A_i ^ op_b;
      OP_SLL:  alu_res = alu_A_i << shamt;
      OP_SRL:  alu_res = alu_A_i >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(alu_A_i) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_A_i) < $signed(op_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (alu_A_i < op_b)};
      default: alu_res = '0;
    endcase
  end

  // One iteration of either engine; {hi_q, lo_q} is the shared accumulator.
  // Multiply: lo_q holds the multiplier, op_q the multiplicand.
  // Divide:   lo_q holds the dividend/quotient, hi_q the remainder, op_q the divisor.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, op_q};
    if (is_div_q) begin
      hi_d = div_ge ? (div_shift[XLEN-1:0] - op_q) : div_shift[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    md_res = sel_hi_q ? hi_d : lo_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      alive_q  <= 1'b0;
      valid_q  <= 1'b0;
      alu_c_q  <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_q     <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (flush_i) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (accept) begin
              if (is_muldiv) begin
                state_q  <= BUSY;
                valid_q  <= 1'b0;
                cnt_q    <= CNT_MAX;
                hi_q     <= '0;
                is_div_q <= alu_op_i[2];
                sel_hi_q <= alu_op_i[0];
                lo_q     <= alu_op_i[2] ? alu_A_i : op_b;
                op_q     <= alu_op_i[2] ? op_b : alu_A_i;
              end else begin
                state_q <= DONE;
                valid_q <= 1'b1;
                alu_c_q <= alu_res;
              end
            end else if ((state_q == DONE) && out_ready_i) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end
          BUSY: begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (cnt_q == '0) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              alu_c_q <= md_res;
            end else begin
              cnt_q <= cnt_q - SHW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid_o = valid_q;
  assign alu_C_o     = alu_c_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit (XLEN=32): vector table, randomized vectors against
// a behavioural model, and hand-written flush/reset/back-pressure sequences.
module tb_execute_unit;
  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [3:0]      alu_op_i;
  logic            alub_sel_i;
  logic [XLEN-1:0] alu_A_i;
  logic [XLEN-1:0] rf_rd2_i;
  logic [XLEN-1:0] sext_ext_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] alu_C_o;
  logic [1:0]      dbg_state_o;

  always #5 clk_i = ~clk_i;

  execute_unit #(.XLEN(XLEN), .MULDIV_EN(1'b1)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .alu_op_i    (alu_op_i),
    .alub_sel_i  (alub_sel_i),
    .alu_A_i     (alu_A_i),
    .rf_rd2_i    (rf_rd2_i),
    .sext_ext_i  (sext_ext_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .alu_C_o     (alu_C_o),
    .dbg_state_o (dbg_state_o)
  );

  typedef struct {
    logic [3:0]  op;
    logic        sel;
    logic [31:0] a;
    logic [31:0] rd2;
    logic [31:0] sext;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t            vq[$];
  logic [XLEN-1:0] exp_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every completed result transfer is matched against exp_q.
  always @(negedge clk_i) begin
    if (rst_n_i && out_valid_o && out_ready_i && !flush_i) begin
      if (exp_q.size() == 0) chk("unexpected_result", 64'(out_valid_o), 64'd0);
      else chk("scoreboard", 64'(alu_C_o), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return {31'b0, ($signed(a) < $signed(b))};
      4'd9:    return {31'b0, (a < b)};
      4'd10:   return p[31:0];
      4'd11:   return p[63:32];
      4'd12:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13:   return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic add_vec(input logic [3:0] op, input logic sel, input logic [31:0] a,
                         input logic [31:0] rd2, input logic [31:0] sext,
                         input logic [31:0] exp, input int lat);
    vec_t v;
    v.op = op; v.sel = sel; v.a = a; v.rd2 = rd2; v.sext = sext; v.exp = exp; v.lat = lat;
    vq.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic scramble();
    alu_A_i    = $urandom();
    rf_rd2_i   = $urandom();
    sext_ext_i = $urandom();
    alu_op_i   = 4'($urandom_range(0, 15));
    alub_sel_i = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input vec_t v);
    int   lat;
    int   waits;
    logic busy_ready;
    alu_op_i = v.op; alub_sel_i = v.sel; alu_A_i = v.a;
    rf_rd2_i = v.rd2; sext_ext_i = v.sext; in_valid_i = 1'b1;
    waits = 0;
    while (!in_ready_o && waits < 100) begin
      tick();
      waits++;
    end
    exp_q.push_back(v.exp);
    tick();
    in_valid_i = 1'b0;
    busy_ready = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 100) begin
      busy_ready |= in_ready_o;
      scramble();
      tick();
      lat++;
    end
    chk($sformatf("latency_op%0d", v.op), 64'(lat), 64'(v.lat));
    if (v.lat > 1) chk($sformatf("ready_in_busy_op%0d", v.op), 64'(busy_ready), 64'd0);
  endtask

  // Presents one request on rf_rd2 and returns one cycle after acceptance.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp);
    alu_op_i = op; alub_sel_i = 1'b0; alu_A_i = a; rf_rd2_i = b; sext_ext_i = ~b;
    in_valid_i = 1'b1;
    if (push) exp_q.push_back(exp);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      seen |= out_valid_o;
      tick();
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    logic stable;
    rst_n_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    alu_op_i = '0; alub_sel_i = 1'b0; alu_A_i = '0; rf_rd2_i = '0; sext_ext_i = '0;

    #3;
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_alu_c", 64'(alu_C_o), 64'd0);
    tick(); tick();
    rst_n_i = 1'b1;
    #1;
    chk("release_in_ready_before_edge", 64'(in_ready_o), 64'd0);
    @(posedge clk_i); #1;
    chk("release_in_ready_after_edge", 64'(in_ready_o), 64'd1);
    chk("release_state", 64'(dbg_state_o), 64'd0);

    add_vec(4'd0,  1'b0, 32'hFFFF_FFFF, 32'd1,         32'hDEAD_BEEF, 32'h0000_0000, 1);
    add_vec(4'd1,  1'b0, 32'd5,         32'd7,         32'd0,         32'hFFFF_FFFE, 1);
    add_vec(4'd2,  1'b1, 32'hF0F0_F0F0, 32'h1234_5678, 32'h0FF0_0FF0, 32'h00F0_00F0, 1);
    add_vec(4'd3,  1'b0, 32'h1234_0000, 32'h0000_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1);
    add_vec(4'd4,  1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0,         32'hF0F0_0F0F, 1);
    add_vec(4'd5,  1'b1, 32'd1,         32'd0,         32'd31,        32'h8000_0000, 1);
    add_vec(4'd6,  1'b1, 32'h8000_0000, 32'd1,         32'h24,        32'h0800_0000, 1);
    add_vec(4'd7,  1'b1, 32'h8000_0000, 32'd0,         32'd4,         32'hF800_0000, 1);
    add_vec(4'd8,  1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd1,         1);
    add_vec(4'd9,  1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0,         1);
    add_vec(4'd10, 1'b0, 32'd7,         32'd6,         32'd0,         32'h2A,        33);
    add_vec(4'd10, 1'b1, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'd1,         33);
    add_vec(4'd11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFE, 33);
    add_vec(4'd11, 1'b0, 32'h8000_0000, 32'd4,         32'd0,         32'd2,         33);
    add_vec(4'd12, 1'b0, 32'd100,       32'd7,         32'd0,         32'd14,        33);
    add_vec(4'd13, 1'b0, 32'd100,       32'd7,         32'd0,         32'd2,         33);
    add_vec(4'd12, 1'b0, 32'd7,         32'd0,         32'd5,         32'hFFFF_FFFF, 33);
    add_vec(4'd13, 1'b1, 32'd7,         32'd3,         32'd0,         32'd7,         33);
    add_vec(4'd12, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 33);
    add_vec(4'd14, 1'b0, 32'h1234_5678, 32'd9,         32'd0,         32'd0,         1);
    add_vec(4'd15, 1'b1, 32'hFFFF_FFFF, 32'd9,         32'd3,         32'd0,         1);

    for (int i = 0; i < 12; i++) begin
      vec_t        v;
      logic [31:0] b;
      v.op  = 4'($urandom_range(0, 13));
      v.sel = 1'($urandom_range(0, 1));
      v.a   = $urandom();
      b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      v.rd2  = v.sel ? $urandom() : b;
      v.sext = v.sel ? b : $urandom();
      v.exp  = model(v.op, v.a, b);
      v.lat  = (v.op >= 4'd10 && v.op <= 4'd13) ? 33 : 1;
      vq.push_back(v);
    end

    foreach (vq[i]) run_op(vq[i]);
    tick();

    // Back-pressure: result held for 5 cycles, then a same-cycle new request.
    out_ready_i = 1'b0;
    issue(4'd4, 32'hA5A5_A5A5, 32'd0, 1'b1, 32'hA5A5_A5A5);
    chk("bp_valid", 64'(out_valid_o), 64'd1);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!out_valid_o || alu_C_o !== 32'hA5A5_A5A5 || in_ready_o) stable = 1'b0;
    end
    chk("bp_hold_stable", 64'(stable), 64'd1);
    out_ready_i = 1'b1;
    alu_op_i = 4'd0; alub_sel_i = 1'b0; alu_A_i = 32'd2; rf_rd2_i = 32'd3; in_valid_i = 1'b1;
    #1;
    chk("b2b_in_ready", 64'(in_ready_o), 64'd1);
    exp_q.push_back(32'd5);
    tick();
    in_valid_i = 1'b0;
    chk("b2b_valid", 64'(out_valid_o), 64'd1);
    chk("b2b_result", 64'(alu_C_o), 64'd5);
    tick();

    // Flush during DIVU iteration 10.
    issue(4'd12, 32'd100, 32'd7, 1'b0, 32'd0);
    for (int i = 0; i < 9; i++) tick();
    chk("flush_busy_state", 64'(dbg_state_o), 64'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("flush_out_valid", 64'(out_valid_o), 64'd0);
    chk("flush_in_ready_next", 64'(in_ready_o), 64'd1);
    watch_no_valid("flush_no_result", 40);
    flush_i = 1'b1;
    #1;
    chk("flush_gates_ready", 64'(in_ready_o), 64'd0);
    flush_i = 1'b0;
    tick();

    // Flush while a result waits in DONE.
    out_ready_i = 1'b0;
    issue(4'd4, 32'h0000_1234, 32'd0, 1'b0, 32'd0);
    chk("flush_done_valid_before", 64'(out_valid_o), 64'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_done_valid_after", 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b1;
    tick();

    // Asynchronous reset during MUL.
    issue(4'd10, 32'd3, 32'd5, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid_o), 64'd0);
    chk("async_rst_alu_c", 64'(alu_C_o), 64'd0);
    chk("async_rst_ready", 64'(in_ready_o), 64'd0);
    chk("async_rst_state", 64'(dbg_state_o), 64'd0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick();
    chk("rst_mul_in_ready_next", 64'(in_ready_o), 64'd1);
    watch_no_valid("rst_mul_no_result", 40);

    begin
      vec_t v;
      v.op = 4'd0; v.sel = 1'b1; v.a = 32'd40; v.rd2 = 32'd0; v.sext = 32'd2;
      v.exp = 32'd42; v.lat = 1;
      run_op(v);
    end
    tick();
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
